// File: rtl/psc_trigger_serializer.sv
// psc_trigger_serializer: 10-bit async frame per slot cycle (trigger or idle code),
// trigger counting and slot-sequence error detection.
module psc_trigger_serializer #(
   parameter logic [7:0] TRIG_CODE = 8'hA5,
   parameter logic [7:0] IDLE_CODE = 8'h55
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        is_trigger,
   input  logic [3:0]  tx_counter,
   input  logic        enable,
   input  logic        err_clr,
   output logic        tx_out,
   output logic        frame_start,
   output logic        trigger_sent,
   output logic [15:0] trigger_count,
   output logic        sync_err
);
   logic        tx_q, tx_d;
   logic        frame_start_q, frame_start_d;
   logic        trigger_sent_q, trigger_sent_d;
   logic [15:0] trigger_count_q, trigger_count_d;
   logic        sync_err_q, sync_err_d;
   logic [7:0]  data_q, data_d;
   logic        frame_active_q, frame_active_d;
   logic        is_trig_frame_q, is_trig_frame_d;
   logic [3:0]  prev_cnt_q, prev_cnt_d;
   logic        prev_valid_q, prev_valid_d;
   logic [3:0]  exp_cnt;
   logic [2:0]  bit_idx;
   logic        err, k0, k9;

   always_comb begin
      exp_cnt         = prev_cnt_q == 4'd9 ? 4'd0 : prev_cnt_q + 4'd1;
      err             = (prev_valid_q && tx_counter != exp_cnt) || tx_counter > 4'd9;
      k0              = tx_counter == 4'd0 && !err;
      k9              = tx_counter == 4'd9 && !err;
      bit_idx         = 3'(tx_counter - 4'd1);
      // a sequence error aborts the frame; the stop slot ends it normally
      frame_active_d  = (err || k9) ? 1'b0 : k0 ? enable : frame_active_q;
      is_trig_frame_d = (err || k9) ? 1'b0 : k0 ? (enable & is_trigger) : is_trig_frame_q;
      data_d          = k0 ? (is_trigger ? TRIG_CODE : IDLE_CODE) : data_q;
      tx_d            = k0 ? !enable
                      : (err || !frame_active_q || tx_counter == 4'd0 || tx_counter == 4'd9) ? 1'b1
                      : data_q[bit_idx];
      frame_start_d   = k0 && enable;
      trigger_sent_d  = k9 && is_trig_frame_q;
      trigger_count_d = trigger_count_q + 16'(trigger_sent_d);
      sync_err_d      = err || (sync_err_q && !err_clr);
      prev_cnt_d      = tx_counter;
      prev_valid_d    = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_q            <= 1'b1;
         frame_start_q   <= 1'b0;
         trigger_sent_q  <= 1'b0;
         trigger_count_q <= 16'd0;
         sync_err_q      <= 1'b0;
         data_q          <= IDLE_CODE;
         frame_active_q  <= 1'b0;
         is_trig_frame_q <= 1'b0;
         prev_cnt_q      <= 4'd0;
         prev_valid_q    <= 1'b0;
      end else begin
         tx_q            <= tx_d;
         frame_start_q   <= frame_start_d;
         trigger_sent_q  <= trigger_sent_d;
         trigger_count_q <= trigger_count_d;
         sync_err_q      <= sync_err_d;
         data_q          <= data_d;
         frame_active_q  <= frame_active_d;
         is_trig_frame_q <= is_trig_frame_d;
         prev_cnt_q      <= prev_cnt_d;
         prev_valid_q    <= prev_valid_d;
      end
   end

   assign tx_out        = tx_q;
   assign frame_start   = frame_start_q;
   assign trigger_sent  = trigger_sent_q;
   assign trigger_count = trigger_count_q;
   assign sync_err      = sync_err_q;
endmodule

// File: tb/tb_psc_trigger_serializer.sv
// tb_psc_trigger_serializer: directed checks of frame content, trigger counting,
// sequence errors, counter wrap and asynchronous reset.
module tb_psc_trigger_serializer;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        is_trigger = 1'b0;
   logic        enable = 1'b1;
   logic        err_clr = 1'b0;
   logic [3:0]  tx_counter = 4'd0;
   logic        tx_out, frame_start, trigger_sent, sync_err;
   logic [15:0] trigger_count;
   int checks = 0;
   int failures = 0;

   // tx_out expectations indexed by slot k (bit k = slot k)
   localparam logic [9:0] IDLE_TX = 10'b1010101010;
   localparam logic [9:0] TRIG_TX = 10'b1101001010;
   localparam logic [9:0] MARK_TX = 10'b1111111111;

   psc_trigger_serializer dut (
      .clk(clk), .reset(reset), .is_trigger(is_trigger), .tx_counter(tx_counter),
      .enable(enable), .err_clr(err_clr), .tx_out(tx_out), .frame_start(frame_start),
      .trigger_sent(trigger_sent), .trigger_count(trigger_count), .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic [3:0] k, input logic en, input logic trig, input logic clr);
      tx_counter = k;
      enable     = en;
      is_trigger = trig;
      err_clr    = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input logic en0, input logic en_rest, input logic trig,
                            input logic [9:0] exp, input logic exp_ts, input string tag);
      for (int k = 0; k < 10; k++) begin
         step(4'(k), k < 3 ? en0 : en_rest, trig, 1'b0);
         check($sformatf("%s_tx%0d", tag, k), 32'(tx_out), 32'(exp[k]));
         check($sformatf("%s_fs%0d", tag, k), 32'(frame_start), 32'(k == 0 && en0));
         check($sformatf("%s_ts%0d", tag, k), 32'(trigger_sent), 32'(k == 9 && exp_ts));
      end
   endtask

   initial begin
      logic [3:0] err_ks [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9};
      logic       err_tx [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      #12;
      check("rst_tx", 32'(tx_out), 32'd1);
      check("rst_fs", 32'(frame_start), 32'd0);
      check("rst_ts", 32'(trigger_sent), 32'd0);
      check("rst_cnt", 32'(trigger_count), 32'd0);
      check("rst_err", 32'(sync_err), 32'd0);
      reset = 1'b1;
      run_frame(1'b1, 1'b1, 1'b0, IDLE_TX, 1'b0, "idle0");
      run_frame(1'b1, 1'b1, 1'b0, IDLE_TX, 1'b0, "idle1");
      check("idle_cnt", 32'(trigger_count), 32'd0);
      run_frame(1'b1, 1'b1, 1'b1, TRIG_TX, 1'b1, "trig");
      check("trig_cnt", 32'(trigger_count), 32'd1);
      run_frame(1'b1, 1'b1, 1'b0, IDLE_TX, 1'b0, "post_trig");
      run_frame(1'b0, 1'b1, 1'b1, MARK_TX, 1'b0, "dis");
      check("dis_cnt", 32'(trigger_count), 32'd1);
      run_frame(1'b1, 1'b1, 1'b0, IDLE_TX, 1'b0, "reen");
      for (int i = 0; i < 8; i++) begin
         step(err_ks[i], 1'b1, 1'b1, 1'b0);
         check($sformatf("jmp_tx%0d", err_ks[i]), 32'(tx_out), 32'(err_tx[i]));
         check($sformatf("jmp_ts%0d", err_ks[i]), 32'(trigger_sent), 32'd0);
      end
      check("jmp_err", 32'(sync_err), 32'd1);
      check("jmp_cnt", 32'(trigger_count), 32'd1);
      run_frame(1'b1, 1'b1, 1'b0, IDLE_TX, 1'b0, "post_jmp");
      check("err_sticky", 32'(sync_err), 32'd1);
      step(4'd0, 1'b1, 1'b0, 1'b1);
      check("clr_err", 32'(sync_err), 32'd0);
      check("clr_tx", 32'(tx_out), 32'd0);
      for (int k = 1; k < 10; k++) step(4'(k), 1'b1, 1'b0, 1'b0);
      check("clr_hold", 32'(sync_err), 32'd0);
      step(4'd12, 1'b1, 1'b0, 1'b1);
      check("oor_err", 32'(sync_err), 32'd1);
      check("oor_tx", 32'(tx_out), 32'd1);
      step(4'd0, 1'b1, 1'b0, 1'b0);
      check("oor_next_tx", 32'(tx_out), 32'd1);
      check("oor_next_fs", 32'(frame_start), 32'd0);
      for (int k = 1; k < 10; k++) step(4'(k), 1'b1, 1'b0, 1'b0);
      check("oor_stop_tx", 32'(tx_out), 32'd1);
      run_frame(1'b1, 1'b1, 1'b0, IDLE_TX, 1'b0, "recover");
      force dut.trigger_count_q = 16'hFFFF;
      #2;
      release dut.trigger_count_q;
      check("preload", 32'(trigger_count), 32'hFFFF);
      run_frame(1'b1, 1'b1, 1'b1, TRIG_TX, 1'b1, "wrap");
      check("wrap_cnt", 32'(trigger_count), 32'd0);
      run_frame(1'b1, 1'b1, 1'b1, TRIG_TX, 1'b1, "trig2");
      check("trig2_cnt", 32'(trigger_count), 32'd1);
      for (int k = 0; k < 6; k++) step(4'(k), 1'b1, 1'b1, 1'b0);
      check("pre_rst_tx", 32'(tx_out), 32'd0);
      #2 reset = 1'b0;
      #1;
      check("arst_tx", 32'(tx_out), 32'd1);
      check("arst_cnt", 32'(trigger_count), 32'd0);
      check("arst_fs", 32'(frame_start), 32'd0);
      check("arst_err", 32'(sync_err), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 6; k < 10; k++) begin
         step(4'(k), 1'b1, 1'b0, 1'b0);
         check($sformatf("partial_tx%0d", k), 32'(tx_out), 32'd1);
      end
      check("partial_err", 32'(sync_err), 32'd0);
      run_frame(1'b1, 1'b1, 1'b0, IDLE_TX, 1'b0, "after_rst");
      check("after_rst_err", 32'(sync_err), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
